sequenciador_ventoinha: RTL

Thermal scheduler that drives the 2-bit level input (s_nivel) of controle_ventoinha and the fan power relay. It turns periodic temperature samples into a target level, with per-threshold hysteresis. It then sequences the fan: a full-speed spin-up kick, single-step ramping with a minimum dwell time, and relay switch-off. A watchdog forces full speed if temperature samples stop arriving.

---
 rtl/ventoinha_pkg.sv | 25 ++
 rtl/classificador_temperatura.sv | 28 ++
 rtl/sequenciador_ventoinha.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ventoinha_pkg.sv
// Shared constants for the fan sequencer: level codes, FSM encoding and
// default thermal/timing parameters.
package ventoinha_pkg;

  localparam logic [1:0] NIVEL_OFF = 2'd0;
  localparam logic [1:0] NIVEL_1   = 2'd1;
  localparam logic [1:0] NIVEL_2   = 2'd2;
  localparam logic [1:0] NIVEL_3   = 2'd3;

  typedef enum logic [2:0] {
    DESLIGADO = 3'd0,
    PARTIDA   = 3'd1,
    OPERANDO  = 3'd2,
    FALHA     = 3'd3
  } estado_t;

  localparam int unsigned LIM1_DEF    = 40;
  localparam int unsigned LIM2_DEF    = 60;
  localparam int unsigned LIM3_DEF    = 80;
  localparam int unsigned HIST_DEF    = 4;
  localparam int unsigned KICK_DEF    = 2000;
  localparam int unsigned DWELL_DEF   = 5000;
  localparam int unsigned TIMEOUT_DEF = 100000;

endpackage

// File: rtl/classificador_temperatura.sv
// Combinational hysteresis classifier: a threshold already reached by the
// current target is lowered by HIST so the level does not chatter.
module classificador_temperatura
  import ventoinha_pkg::*;
#(
  parameter int unsigned LIM1 = LIM1_DEF,
  parameter int unsigned LIM2 = LIM2_DEF,
  parameter int unsigned LIM3 = LIM3_DEF,
  parameter int unsigned HIST = HIST_DEF
) (
  input  logic [7:0] temp,
  input  logic [1:0] alvo_atual,
  output logic [1:0] alvo_novo
);

  localparam logic [2:0][7:0] LIM = {8'(LIM3), 8'(LIM2), 8'(LIM1)};

  logic [2:0] acima;

  for (genvar k = 0; k < 3; k++) begin : g_lim
    logic [7:0] thr;
    assign thr      = (alvo_atual > 2'(k)) ? LIM[k] - 8'(HIST) : LIM[k];
    assign acima[k] = temp >= thr;
  end

  assign alvo_novo = {1'b0, acima[0]} + {1'b0, acima[1]} + {1'b0, acima[2]};

endmodule

// File: rtl/sequenciador_ventoinha.sv
// Fan sequencer: classifies temperature into a target level, kicks the fan at
// full speed on start, ramps one step per dwell period, and fails safe on silence.
module sequenciador_ventoinha
  import ventoinha_pkg::*;
#(
  parameter int unsigned LIM1    = LIM1_DEF,
  parameter int unsigned LIM2    = LIM2_DEF,
  parameter int unsigned LIM3    = LIM3_DEF,
  parameter int unsigned HIST    = HIST_DEF,
  parameter int unsigned KICK    = KICK_DEF,
  parameter int unsigned DWELL   = DWELL_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] temp,
  input  logic       temp_valid,
  output logic [1:0] s_nivel,
  output logic       rele,
  output logic       falha,
  output logic [2:0] db_estado
);

  localparam int KW = $clog2(KICK + 1);
  localparam int DW = $clog2(DWELL + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  estado_t       estado, estado_nx;
  logic [1:0]    nivel, nivel_nx;
  logic [1:0]    alvo, alvo_cls;
  logic [KW-1:0] cnt_kick, cnt_kick_nx;
  logic [DW-1:0] cnt_dwell, cnt_dwell_nx;
  logic [WW-1:0] cnt_wd, cnt_wd_nx;
  logic          expira;

  classificador_temperatura #(
    .LIM1(LIM1), .LIM2(LIM2), .LIM3(LIM3), .HIST(HIST)
  ) u_cls (
    .temp      (temp),
    .alvo_atual(alvo),
    .alvo_novo (alvo_cls)
  );

  // A sample landing on the would-be timeout cycle clears the counter first.
  always_comb begin
    cnt_wd_nx = cnt_wd;
    if (temp_valid)                   cnt_wd_nx = '0;
    else if (cnt_wd != WW'(TIMEOUT))  cnt_wd_nx = cnt_wd + 1'b1;
  end

  assign expira = !temp_valid && (cnt_wd == WW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= DESLIGADO;
      nivel     <= NIVEL_OFF;
      alvo      <= NIVEL_OFF;
      cnt_kick  <= '0;
      cnt_dwell <= '0;
      cnt_wd    <= '0;
    end else begin
      estado    <= estado_nx;
      nivel     <= nivel_nx;
      cnt_kick  <= cnt_kick_nx;
      cnt_dwell <= cnt_dwell_nx;
      cnt_wd    <= cnt_wd_nx;
      if (temp_valid) alvo <= alvo_cls;
    end
  end

  always_comb begin
    estado_nx    = estado;
    nivel_nx     = nivel;
    cnt_kick_nx  = cnt_kick;
    cnt_dwell_nx = cnt_dwell;
    if (expira) begin
      estado_nx = FALHA;
      nivel_nx  = NIVEL_3;
    end else begin
      case (estado)
        DESLIGADO: if (alvo != NIVEL_OFF) begin
          estado_nx   = PARTIDA;
          nivel_nx    = NIVEL_3;
          cnt_kick_nx = '0;
        end
        PARTIDA: if (cnt_kick == KW'(KICK - 1)) begin
          // Never leave the kick straight to off; the ramp takes it down.
          estado_nx    = OPERANDO;
          nivel_nx     = (alvo == NIVEL_OFF) ? NIVEL_1 : alvo;
          cnt_dwell_nx = '0;
        end else begin
          cnt_kick_nx = cnt_kick + 1'b1;
        end
        OPERANDO: if (nivel == alvo) begin
          cnt_dwell_nx = '0;
        end else if (cnt_dwell == DW'(DWELL - 1)) begin
          cnt_dwell_nx = '0;
          nivel_nx     = (alvo > nivel) ? nivel + 2'd1 : nivel - 2'd1;
          if (nivel == NIVEL_1 && alvo == NIVEL_OFF) estado_nx = DESLIGADO;
        end else begin
          cnt_dwell_nx = cnt_dwell + 1'b1;
        end
        FALHA: if (temp_valid) begin
          estado_nx    = OPERANDO;
          nivel_nx     = NIVEL_3;
          cnt_dwell_nx = '0;
        end
        default: begin
          estado_nx = DESLIGADO;
          nivel_nx  = NIVEL_OFF;
        end
      endcase
    end
  end

  assign s_nivel   = nivel;
  assign rele      = (estado != DESLIGADO);
  assign falha     = (estado == FALHA);
  assign db_estado = estado;

endmodule
